// File: rtl/hdmi_pack_gen.sv
// hdmi_pack_gen: video timing and test-pattern source
// emitting the packed {clk,hs,vs,de,rgb,x,y} stream.
module hdmi_pack_gen #(
    parameter int H_ACT  = 1280,
    parameter int V_ACT  = 720,
    parameter int H_FP   = 110,
    parameter int H_SYNC = 40,
    parameter int H_BP   = 220,
    parameter int V_FP   = 5,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 20,
    localparam int PACK_SIZE = 3*8 + 4 + $clog2(H_ACT) + $clog2(V_ACT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [1:0]           pat_sel,
    input  logic [23:0]          solid_rgb,
    output logic [PACK_SIZE-1:0] o_pack,
    output logic                 frame_start
);

    localparam int XW    = $clog2(H_ACT);
    localparam int YW    = $clog2(V_ACT);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int BAR_W = H_ACT / 8;

    localparam logic [15:0] H_LAST = 16'(H_TOT - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOT - 1);
    localparam logic [15:0] H_ACTC = 16'(H_ACT);
    localparam logic [15:0] V_ACTC = 16'(V_ACT);
    localparam logic [15:0] HS_BEG = 16'(H_ACT + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACT + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACT + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACT + V_FP + V_SYNC);
    localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state, state_nxt;
    logic        latch;
    logic [15:0] h_cnt, v_cnt;
    logic [15:0] bar_pos;
    logic [2:0]  bar_idx;
    logic [1:0]  pat_q;
    logic [23:0] solid_q;
    logic        end_frame;
    logic        run;
    logic        de_c, hs_c, vs_c;
    logic [23:0] bar_rgb, rgb_c;
    logic        hs_q, vs_q, de_q;
    logic [23:0] rgb_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    assign run       = (state == RUN);
    assign end_frame = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state; latch strobe fires when entering pixel (0,0) in RUN
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    latch     = 1'b1;
                end
            end
            RUN: begin
                if (end_frame) begin
                    if (en) latch = 1'b1;
                    else    state_nxt = IDLE;
                end
            end
        endcase
    end

    // raster counters plus colour-bar position tracking the current h_cnt
    always_ff @(posedge clk) begin
        if (!rstn || !run) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt   <= '0;
            v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + 16'd1;
            bar_pos <= '0;
            bar_idx <= '0;
        end else begin
            h_cnt <= h_cnt + 16'd1;
            if (bar_pos == BAR_LAST) begin
                bar_pos <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pos <= bar_pos + 16'd1;
            end
        end
    end

    // pattern controls are frozen for the whole frame
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pat_q   <= '0;
            solid_q <= '0;
        end else if (latch) begin
            pat_q   <= pat_sel;
            solid_q <= solid_rgb;
        end
    end

    assign de_c = run && (h_cnt < H_ACTC) && (v_cnt < V_ACTC);
    assign hs_c = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_c = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // pattern colour for the current counter position
    always_comb begin
        bar_rgb = '0;
        rgb_c   = '0;
        unique case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            3'd7: bar_rgb = 24'h000000;
        endcase
        unique case (pat_q)
            2'd0: rgb_c = bar_rgb;
            2'd1: rgb_c = {3{h_cnt[7:0]}};
            2'd2: rgb_c = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h0;
            2'd3: rgb_c = solid_q;
        endcase
    end

    // output stage, one cycle behind the counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            frame_start <= 1'b0;
        end else begin
            hs_q        <= hs_c;
            vs_q        <= vs_c;
            de_q        <= de_c;
            rgb_q       <= de_c ? rgb_c : '0;
            x_q         <= de_c ? h_cnt[XW-1:0] : '0;
            y_q         <= de_c ? v_cnt[YW-1:0] : '0;
            frame_start <= run && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign o_pack = {clk, hs_q, vs_q, de_q, rgb_q, x_q, y_q};

endmodule

// File: tb/tb_hdmi_pack_gen.sv
// tb_hdmi_pack_gen: directed checks of timing, patterns,
// enable handling and reset on a small raster.
module tb_hdmi_pack_gen;

    localparam int PS = 34;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [1:0]    pat_sel;
    logic [23:0]   solid_rgb;
    logic [PS-1:0] o_pack;
    logic          frame_start;

    int n_tot = 0;
    int n_bad = 0;

    logic [PS-1:0] cap [0:191];
    logic          fs_cap [0:191];

    hdmi_pack_gen #(
        .H_ACT(16), .V_ACT(4), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .pat_sel(pat_sel),
        .solid_rgb(solid_rgb),
        .o_pack(o_pack),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // record 192 output samples starting with the current one
    task automatic cap_frame();
        for (int i = 0; i < 192; i++) begin
            cap[i]    = o_pack;
            fs_cap[i] = frame_start;
            @(negedge clk);
        end
    endtask

    function automatic logic [23:0] rgb_of(input logic [PS-1:0] p);
        return p[29:6];
    endfunction

    initial begin
        int n_de, n_hs, n_vs, n_fs;
        rstn      = 1'b0;
        en        = 1'b0;
        pat_sel   = 2'd1;
        solid_rgb = 24'h0;
        repeat (3) @(negedge clk);
        chk("rst_pack", 32'(o_pack[32:0]), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        @(posedge clk);
        #1 chk("clk_bit_hi", 32'(o_pack[33]), 32'h1);
        @(negedge clk);
        chk("clk_bit_lo", 32'(o_pack[33]), 32'h0);

        rstn = 1'b1;
        @(negedge clk);
        chk("idle_hold", 32'(o_pack[32:0]), 32'h0);

        en = 1'b1;
        @(negedge clk);
        chk("lat_n1", 32'(o_pack[32:0]), 32'h0);
        @(negedge clk);
        chk("lat_fs", 32'(frame_start), 32'h1);
        chk("lat_de", 32'(o_pack[30]), 32'h1);
        chk("lat_xy", 32'(o_pack[5:0]), 32'h0);

        // frame 1: gradient, pat change must wait a frame
        pat_sel = 2'd0;
        cap_frame();
        chk("fs_period", 32'(frame_start), 32'h1);
        n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
        for (int i = 0; i < 192; i++) begin
            n_de += int'(cap[i][30]);
            n_hs += int'(cap[i][32]);
            n_vs += int'(cap[i][31]);
            n_fs += int'(fs_cap[i]);
        end
        chk("de_cnt", 32'(n_de), 32'd64);
        chk("hs_cnt", 32'(n_hs), 32'd24);
        chk("vs_cnt", 32'(n_vs), 32'd48);
        chk("fs_cnt", 32'(n_fs), 32'd1);
        chk("hs_h17", 32'(cap[17][32]), 32'h0);
        chk("hs_h18", 32'(cap[18][32]), 32'h1);
        chk("hs_h20", 32'(cap[20][32]), 32'h1);
        chk("hs_h21", 32'(cap[21][32]), 32'h0);
        chk("hs_vblank", 32'(cap[6*24+18][32]), 32'h1);
        chk("vs_l4", 32'(cap[119][31]), 32'h0);
        chk("vs_l5", 32'(cap[120][31]), 32'h1);
        chk("vs_l6", 32'(cap[167][31]), 32'h1);
        chk("vs_l7", 32'(cap[168][31]), 32'h0);
        chk("de_x15", 32'(cap[15][30]), 32'h1);
        chk("de_x16", 32'(cap[16][30]), 32'h0);
        chk("de_l4", 32'(cap[96][30]), 32'h0);
        chk("grad_rgb", 32'(rgb_of(cap[31])), 32'h070707);
        chk("grad_x", 32'(cap[31][5:2]), 32'd7);
        chk("grad_y", 32'(cap[31][1:0]), 32'd1);
        chk("blank_rgb", 32'(rgb_of(cap[16])), 32'h0);

        // frame 2: colour bars
        pat_sel   = 2'd3;
        solid_rgb = 24'h123456;
        cap_frame();
        chk("bar_x0", 32'(rgb_of(cap[48])), 32'hFFFFFF);
        chk("bar_x1", 32'(rgb_of(cap[49])), 32'hFFFFFF);
        chk("bar_x2", 32'(rgb_of(cap[50])), 32'hFFFF00);
        chk("bar_x3", 32'(rgb_of(cap[51])), 32'hFFFF00);
        chk("bar_x4", 32'(rgb_of(cap[52])), 32'h00FFFF);
        chk("bar_x10", 32'(rgb_of(cap[58])), 32'hFF0000);
        chk("bar_x14", 32'(rgb_of(cap[62])), 32'h000000);
        chk("bar_x15", 32'(rgb_of(cap[63])), 32'h000000);
        chk("bar_l0x2", 32'(rgb_of(cap[2])), 32'hFFFF00);

        // frame 3: solid, changed value must not leak in
        solid_rgb = 24'hABCDEF;
        cap_frame();
        chk("solid_00", 32'(rgb_of(cap[0])), 32'h123456);
        chk("solid_end", 32'(rgb_of(cap[72+15])), 32'h123456);
        chk("solid_next", 32'(rgb_of(o_pack)), 32'hABCDEF);

        // frame 4: drop en on line 2, frame must complete
        n_de = 0; n_fs = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 48) en = 1'b0;
            n_de += int'(o_pack[30]);
            n_fs += int'(frame_start);
            @(negedge clk);
        end
        chk("drop_de", 32'(n_de), 32'd64);
        chk("drop_fs", 32'(n_fs), 32'd1);
        chk("drop_idle", 32'(o_pack[32:0]), 32'h0);

        en = 1'b1;
        @(negedge clk);
        chk("reen_n1", 32'(o_pack[32:0]), 32'h0);
        @(negedge clk);
        chk("reen_fs", 32'(frame_start), 32'h1);

        // reset while counters sit at h=5,v=1
        repeat (28) @(negedge clk);
        chk("pre_rst_x", 32'(o_pack[5:2]), 32'd4);
        chk("pre_rst_y", 32'(o_pack[1:0]), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst", 32'(o_pack[32:0]), 32'h0);
        chk("mid_rst_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_rel_n1", 32'(o_pack[32:0]), 32'h0);
        @(negedge clk);
        chk("rst_rel_fs", 32'(frame_start), 32'h1);
        chk("rst_rel_de", 32'(o_pack[30]), 32'h1);
        chk("rst_rel_xy", 32'(o_pack[5:0]), 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/hdmi_pack_gen.md
# hdmi_pack_gen

Video timing and test-pattern source that produces the packed HDMI stream consumed by `hdmi_unpack` and downstream line buffers. It generates hsync/vsync/de, pixel coordinates and a selectable RGB pattern on a single pixel clock. It sits at the head of the processing chain as a camera/HDMI-in stand-in for bring-up and line-buffer/filter verification.

## Interface
- `H_ACT`, 12'd1280, active pixels per line
- `V_ACT`, 12'd720, active lines per frame
- `H_FP`, 110, horizontal front porch (clocks)
- `H_SYNC`, 40, hsync width (clocks)
- `H_BP`, 220, horizontal back porch (clocks)
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vsync width (lines)
- `V_BP`, 20, vertical back porch (lines)
- `PACK_SIZE` (localparam), 3*8+4+$clog2(H_ACT)+$clog2(V_ACT)
- `clk` in 1: pixel clock
- `rstn` in 1: synchronous, active-low reset
- `en` in 1: run enable
- `pat_sel` in 2: pattern select (0 bars, 1 gradient, 2 checker, 3 solid)
- `solid_rgb` in 24: {r,g,b} for pattern 3
- `o_pack` out PACK_SIZE: {clk, hsync, vsync, de, r, g, b, x, y}, MSB first
- `frame_start` out 1: one-cycle pulse on first active pixel of each frame

## Operation
- Counters: `h_cnt` 0..H_TOT-1, H_TOT=H_ACT+H_FP+H_SYNC+H_BP; `v_cnt` 0..V_TOT-1, V_TOT likewise. `v_cnt` advances when `h_cnt` wraps; both wrap to 0 at end of frame.
- Region order per line/frame: active, front porch, sync, back porch.
- de = (h_cnt<H_ACT) && (v_cnt<V_ACT).
- hsync high (active-high) for h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC), on every line including vertical blanking.
- vsync high for entire lines v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC).
- x = h_cnt, y = v_cnt truncated to field width while de=1; x=0, y=0 when de=0. r/g/b = 0 when de=0.
- State machine: IDLE (counters held 0, all outputs 0 except clk bit) -> RUN on `en`=1; RUN -> IDLE at end of frame (h_cnt=H_TOT-1, v_cnt=V_TOT-1) if `en`=0 at that cycle. `en` deasserting mid-frame never truncates a frame.
- `pat_sel` and `solid_rgb` latched at frame start (entering h=0,v=0 in RUN); changes mid-frame have no effect until next frame.
- Pattern 0, colour bars: BAR_W=H_ACT/8 (elaboration-time integer division); bar index increments every BAR_W pixels, saturates at 7, resets each line. Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Pattern 1, gradient: r=g=b=x[7:0] (wraps every 256 pixels).
- Pattern 2, checker: x[5]^y[5] ? FFFFFF : 000000 (32x32 squares).
- Pattern 3, solid: latched `solid_rgb`.
- `o_pack` clk bit is `clk` passed through combinationally; all other pack fields registered.

## Timing
- All registered outputs reset to 0; counters 0; state IDLE. Reset mid-frame: next cycle outputs 0, restart from h=0,v=0 only after `rstn`=1 and `en`=1.
- Latency: `en` sampled 1 at cycle N in IDLE -> counters at (0,0) at N+1 -> first pixel (de=1, x=0, y=0, `frame_start`=1) on `o_pack` at N+2.
- Outputs lag counters by exactly one cycle; hsync, vsync, de, rgb, x, y mutually aligned.
- Back-to-back frames in RUN: no gap cycles between last back-porch clock and next frame's first active pixel.
- `frame_start` high for exactly one cycle per frame, coincident with de of pixel (0,0).

## Test plan
- Small params H_ACT=16,V_ACT=4,H_FP=2,H_SYNC=3,H_BP=3,V_FP=1,V_SYNC=2,V_BP=1; en=1 -> 24 clocks/line, 8 lines/frame, 64 de cycles/frame, hsync high 3 clocks starting at h=18, vsync high lines 5-6, frame_start every 192 clocks.
- Same params, pat_sel=0 -> BAR_W=2; pixels x=0,1 FFFFFF, x=2,3 FFFF00, x=14,15 000000 on every active line.
- pat_sel=3, solid_rgb=123456 changed to ABCDEF mid-frame -> current frame stays 123456, next frame ABCDEF from pixel (0,0).
- Drop en at line 2 of a frame -> frame completes all 8 lines, then outputs 0 and no further frame_start; re-raise en -> first pixel 2 cycles later.
- Assert rstn=0 at h=5,v=1 -> next cycle de/hsync/vsync/rgb/x/y=0; release with en=1 -> frame restarts at (0,0) with frame_start.
- Default 720p params, pat_sel=2 -> 1650x750 clocks/frame, 921600 de cycles; pixel (32,0) FFFFFF, (32,32) 000000, (0,0) 000000.
